pipe_hazard_ctrl: RTL

Parametrised hazard and flush controller for the 5-stage MIPS pipeline (fetch/decode/execute/memory/writeback).
- Tracks destination-register records for instructions in EX, MEM and WB.
- Generates load-use stalls, EX-stage forwarding selects, and branch squash of younger stages when the MEM stage resolves a taken branch.
- Adds stall, bubble and flush control that the current straight-through pipeline does not have; configurable register-address width and load-use latency.

---
 rtl/pipe_hazard_ctrl.sv | 208 ++++++++++++++++++++
 1 files changed

// File: rtl/pipe_hazard_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : pipe_hazard_ctrl
// Brief    : Load-use stall, EX forwarding select and branch squash control for
//            a 5-stage MIPS pipeline. Optional counters via HAZ_PERF_EN.
// Revision : 1.0  initial release
// ============================================================================
module pipe_hazard_ctrl #(
   parameter int AW       = 5,
   parameter int LOAD_LAT = 1,
   parameter int ZERO_REG = 1
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          id_valid,
   input  logic [AW-1:0] id_rs,
   input  logic [AW-1:0] id_rt,
   input  logic          id_uses_rs,
   input  logic          id_uses_rt,
   input  logic [AW-1:0] id_rd,
   input  logic          id_regwrite,
   input  logic          id_memread,
   input  logic          mem_pcsrc,
   output logic          pc_write,
   output logic          if_id_write,
   output logic          id_ex_bubble,
   output logic          if_id_flush,
   output logic          id_ex_flush,
   output logic          ex_mem_flush,
   output logic [1:0]    fwd_a,
   output logic [1:0]    fwd_b,
   output logic          ex_valid,
   output logic          mem_valid,
`ifdef HAZ_PERF_EN
   output logic [31:0]   stall_cnt,
   output logic [31:0]   flush_cnt,
`endif
   output logic          wb_valid
);

   localparam logic c_zero_en = (ZERO_REG != 0);

   // EX record
   logic          r_ex_valid;
   logic [AW-1:0] r_ex_rs;
   logic [AW-1:0] r_ex_rt;
   logic          r_ex_uses_rs;
   logic          r_ex_uses_rt;
   logic [AW-1:0] r_ex_rd;
   logic          r_ex_regwrite;
   logic          r_ex_memread;
   // MEM record
   logic          r_mem_valid;
   logic [AW-1:0] r_mem_rd;
   logic          r_mem_regwrite;
   logic          r_mem_memread;
   // WB record (the load flag is never consulted past MEM)
   logic          r_wb_valid;
   logic [AW-1:0] r_wb_rd;
   logic          r_wb_regwrite;

   logic w_ex_load_a;
   logic w_ex_load_b;
   logic w_mem_load_a;
   logic w_mem_load_b;
   logic w_haz_a;
   logic w_haz_b;
   logic w_load_hazard;
   logic w_stall;
   logic w_flush;
   logic w_ex_take;

   function automatic logic f_match(
      input logic          valid,
      input logic          regwrite,
      input logic [AW-1:0] rd,
      input logic [AW-1:0] r
   );
      f_match = valid & regwrite & (rd == r) & ~(c_zero_en & (r == '0));
   endfunction

   assign w_ex_load_a = f_match(r_ex_valid, r_ex_regwrite, r_ex_rd, id_rs) & r_ex_memread;
   assign w_ex_load_b = f_match(r_ex_valid, r_ex_regwrite, r_ex_rd, id_rt) & r_ex_memread;

   // A two-stage load-use distance also blocks on a load sitting in MEM
   generate
      if (LOAD_LAT == 2) begin : g_lat2
         assign w_mem_load_a = f_match(r_mem_valid, r_mem_regwrite, r_mem_rd, id_rs) & r_mem_memread;
         assign w_mem_load_b = f_match(r_mem_valid, r_mem_regwrite, r_mem_rd, id_rt) & r_mem_memread;
      end else begin : g_lat1
         assign w_mem_load_a = 1'b0;
         assign w_mem_load_b = 1'b0;
      end
   endgenerate

   assign w_haz_a       = id_uses_rs & (w_ex_load_a | w_mem_load_a);
   assign w_haz_b       = id_uses_rt & (w_ex_load_b | w_mem_load_b);
   assign w_load_hazard = id_valid & (w_haz_a | w_haz_b);
   assign w_stall       = w_load_hazard & ~mem_pcsrc & ~rst;
   assign w_flush       = mem_pcsrc & ~rst;
   assign w_ex_take     = id_valid & ~w_stall & ~mem_pcsrc;

   assign pc_write     = ~w_stall;
   assign if_id_write  = ~w_stall;
   assign id_ex_bubble = w_stall;
   assign if_id_flush  = w_flush;
   assign id_ex_flush  = w_flush;
   assign ex_mem_flush = w_flush;
   assign ex_valid     = r_ex_valid;
   assign mem_valid    = r_mem_valid;
   assign wb_valid     = r_wb_valid;

   always_ff @(posedge clk) begin
      if (rst) begin
         r_ex_valid     <= 1'b0;
         r_ex_rs        <= '0;
         r_ex_rt        <= '0;
         r_ex_uses_rs   <= 1'b0;
         r_ex_uses_rt   <= 1'b0;
         r_ex_rd        <= '0;
         r_ex_regwrite  <= 1'b0;
         r_ex_memread   <= 1'b0;
         r_mem_valid    <= 1'b0;
         r_mem_rd       <= '0;
         r_mem_regwrite <= 1'b0;
         r_mem_memread  <= 1'b0;
         r_wb_valid     <= 1'b0;
         r_wb_rd        <= '0;
         r_wb_regwrite  <= 1'b0;
      end else begin
         // Bubbles and squashed slots carry all-zero fields
         if (w_ex_take) begin
            r_ex_valid    <= 1'b1;
            r_ex_rs       <= id_rs;
            r_ex_rt       <= id_rt;
            r_ex_uses_rs  <= id_uses_rs;
            r_ex_uses_rt  <= id_uses_rt;
            r_ex_rd       <= id_rd;
            r_ex_regwrite <= id_regwrite;
            r_ex_memread  <= id_memread;
         end else begin
            r_ex_valid    <= 1'b0;
            r_ex_rs       <= '0;
            r_ex_rt       <= '0;
            r_ex_uses_rs  <= 1'b0;
            r_ex_uses_rt  <= 1'b0;
            r_ex_rd       <= '0;
            r_ex_regwrite <= 1'b0;
            r_ex_memread  <= 1'b0;
         end

         if (mem_pcsrc) begin
            r_mem_valid    <= 1'b0;
            r_mem_rd       <= '0;
            r_mem_regwrite <= 1'b0;
            r_mem_memread  <= 1'b0;
         end else begin
            r_mem_valid    <= r_ex_valid;
            r_mem_rd       <= r_ex_rd;
            r_mem_regwrite <= r_ex_regwrite;
            r_mem_memread  <= r_ex_memread;
         end

         // The branch itself retires into WB even when it squashes the rest
         r_wb_valid    <= r_mem_valid;
         r_wb_rd       <= r_mem_rd;
         r_wb_regwrite <= r_mem_regwrite;
      end
   end

   always_comb begin
      fwd_a = 2'b00;
      fwd_b = 2'b00;
      if (!rst) begin
         if (f_match(r_mem_valid, r_mem_regwrite, r_mem_rd, r_ex_rs) && !r_mem_memread && r_ex_uses_rs)
            fwd_a = 2'b10;
         else if (f_match(r_wb_valid, r_wb_regwrite, r_wb_rd, r_ex_rs))
            fwd_a = 2'b01;

         if (f_match(r_mem_valid, r_mem_regwrite, r_mem_rd, r_ex_rt) && !r_mem_memread && r_ex_uses_rt)
            fwd_b = 2'b10;
         else if (f_match(r_wb_valid, r_wb_regwrite, r_wb_rd, r_ex_rt))
            fwd_b = 2'b01;
      end
   end

`ifdef HAZ_PERF_EN
   logic [31:0] r_stall_cnt;
   logic [31:0] r_flush_cnt;

   always_ff @(posedge clk) begin
      if (rst) begin
         r_stall_cnt <= '0;
         r_flush_cnt <= '0;
      end else begin
         if (w_stall && (r_stall_cnt != 32'hFFFF_FFFF))
            r_stall_cnt <= r_stall_cnt + 32'd1;
         if (w_flush && (r_flush_cnt != 32'hFFFF_FFFF))
            r_flush_cnt <= r_flush_cnt + 32'd1;
      end
   end

   assign stall_cnt = r_stall_cnt;
   assign flush_cnt = r_flush_cnt;
`endif

endmodule
`default_nettype wire
